// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the saturation bound helper.
package bin2bcd_seq_pkg;

  localparam int DEF_IN_WIDTH = 16;
  localparam int DEF_DIGITS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest value representable in the given number of BCD digits (10^digits - 1).
  function automatic longint unsigned max_bcd_value(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a score source and the BCD converter.
// Handshake: start is a request sampled only while busy is low; a request seen
// while busy is dropped. done pulses for one cycle when bcd/ovf carry a new result.
interface bin2bcd_seq_if #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 4
);
  logic [IN_WIDTH-1:0]  value;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd;
  logic                 ovf;

  modport master (output value, output start, input busy, input done, input bcd, input ovf);
  modport slave  (input value, input start, output busy, output done, output bcd, output ovf);
endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);
  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Values above the digit range saturate to all nines with ovf set.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int DIGITS   = DEF_DIGITS
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus,
  output state_t        state_dbg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH) + 1;
  localparam logic [63:0] MAX_VAL = 64'(max_bcd_value(DIGITS));

  state_t              state;
  state_t              state_nxt;
  logic [BCD_W-1:0]    scratch;
  logic [BCD_W-1:0]    adj;
  logic [IN_WIDTH-1:0] operand;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_pend;
  logic [BCD_W-1:0]    bcd_q;
  logic                ovf_q;
  logic                done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[4*g +: 4]),
      .adj   (adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_W'(IN_WIDTH - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Overflow is judged directly on the captured value; carries out of the
  // top scratch digit are simply lost because this flag replaces the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch  <= '0;
      operand  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            operand  <= bus.value;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 64'(bus.value) > MAX_VAL;
          end
        end
        ST_SHIFT: begin
          {scratch, operand} <= {adj, operand} << 1;
          cnt                <= cnt + CNT_W'(1);
        end
        ST_DONE: begin
          bcd_q  <= ovf_pend ? {DIGITS{4'h9}} : scratch;
          ovf_q  <= ovf_pend;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != ST_IDLE);
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.ovf   = ovf_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases, a back-to-back
// streaming run and randomized conversions against a decimal-arithmetic model.
module tb_bin2bcd_seq;
  import bin2bcd_seq_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     n_checks;
  int     n_errors;
  logic [15:0] exp_q[$];

  bin2bcd_seq_if #(.IN_WIDTH(16), .DIGITS(4)) bus ();

  bin2bcd_seq #(.IN_WIDTH(16), .DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, saturated to 9999.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    x = (v > 9999) ? 9999 : v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Single start pulse, then wait for done; lat counts edges after the sampling edge.
  task automatic run_conv(input int unsigned v, output int lat, output int busy_cyc);
    bus.value = 16'(v);
    bus.start = 1'b1;
    busy_cyc  = 0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic conv_and_check(input string tag, input int unsigned v);
    int lat;
    int bc;
    run_conv(v, lat, bc);
    check_eq({tag, "_lat"}, 64'(lat), 64'd17);
    check_eq({tag, "_busy_cycles"}, 64'(bc), 64'd17);
    check_eq({tag, "_bcd"}, 64'(bus.bcd), 64'(ref_bcd(v)));
    check_eq({tag, "_ovf"}, 64'(bus.ovf), 64'(v > 9999));
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_bcd_hold"}, 64'(bus.bcd), 64'(ref_bcd(v)));
  endtask

  initial begin
    int lat;
    int bc;
    int gap;
    int n_done;
    logic [15:0] hold_bcd;
    logic [15:0] exp;
    int unsigned rv;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.value = '0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_bcd", 64'(bus.bcd), 64'd0);
    check_eq("rst_ovf", 64'(bus.ovf), 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    rst_n = 1'b1;

    // first edge after release must accept start
    conv_and_check("zero", 0);
    conv_and_check("v1234", 1234);
    conv_and_check("v9999", 9999);
    conv_and_check("v10000", 10000);
    conv_and_check("v65535", 65535);
    conv_and_check("v1", 1);

    // start re-pulsed mid-conversion with a new value must be ignored
    bus.value = 16'd42;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_done = 0;
    hold_bcd = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        bus.value = 16'd77;
        bus.start = 1'b1;
      end else if (k == 6) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        hold_bcd = bus.bcd;
      end
    end
    check_eq("restart_done_count", 64'(n_done), 64'd1);
    check_eq("restart_bcd", 64'(hold_bcd), 64'h0042);
    conv_and_check("v77", 77);

    // reset in the middle of a conversion
    bus.value = 16'd5555;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_done = 0;
    repeat (7) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    check_eq("midrst_done", 64'(bus.done), 64'd0);
    check_eq("midrst_bcd", 64'(bus.bcd), 64'd0);
    check_eq("midrst_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check_eq("midrst_no_done", 64'(n_done), 64'd0);
    check_eq("midrst_bcd_after", 64'(bus.bcd), 64'd0);
    conv_and_check("v5555", 5555);

    // start held high: streaming values 1..200
    bus.value = 16'd1;
    bus.start = 1'b1;
    exp_q.push_back(ref_bcd(1));
    for (int i = 1; i <= 200; i++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!bus.done && gap < 60);
      check_eq("stream_gap", 64'(gap), 64'd18);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check_eq("stream_bcd", 64'(bus.bcd), 64'(exp));
      check_eq("stream_ovf", 64'(bus.ovf), 64'd0);
      if (i < 200) begin
        bus.value = 16'(i + 1);
        exp_q.push_back(ref_bcd(unsigned'(i + 1)));
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("stream_stop_busy", 64'(bus.busy), 64'd0);

    // randomized conversions with random idle gaps
    for (int i = 0; i < 40; i++) begin
      rv = (i % 4 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 9999);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      conv_and_check("rand", rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
